// File: rtl/pwm_decoder.sv
// PWM receive-side decoder: synchronises an asynchronous PWM waveform and
// recovers its duty code and period, flagging off-nominal periods and stuck inputs.
module pwm_decoder #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PERIOD  = 256,
  parameter int unsigned TOL     = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [7:0]       duty_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             period_err,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PER_LO   = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] PER_HI   = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(255);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_d;
  logic             sync1, s, s_prev;
  logic             rise, fall, timeout_hit;
  logic [CNT_W-1:0] hi_cnt, per_cnt, hi_cnt_d, per_cnt_d;
  logic [CNT_W-1:0] hi_inc, per_inc;
  logic [7:0]       duty_d;
  logic [CNT_W-1:0] period_d;
  logic             valid_d, period_err_d, stuck_d;

  // Two-flop synchroniser followed by the previous-level flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      s      <= sync1;
      s_prev <= s;
    end
  end

  assign rise    = s & ~s_prev;
  assign fall    = ~s & s_prev;
  assign hi_inc  = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + CNT_ONE;
  assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;

  // A rise at the timeout cycle wins; an already-reported stall in IDLE stays silent
  assign timeout_hit = (per_cnt == TO_VAL) && !rise && !((state == IDLE) && stuck);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (rise) state_d = HIGH;
      HIGH: begin
        if (timeout_hit)  state_d = IDLE;
        else if (fall)    state_d = LOW;
      end
      LOW: begin
        if (rise)             state_d = HIGH;
        else if (timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hi_cnt_d     = hi_cnt;
    per_cnt_d    = per_cnt;
    duty_d       = duty_out;
    period_d     = period_out;
    period_err_d = period_err;
    stuck_d      = stuck;
    valid_d      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          hi_cnt_d  = CNT_ONE;
          per_cnt_d = CNT_ONE;
        end else begin
          if (per_cnt != TO_VAL) per_cnt_d = per_inc;
          if (timeout_hit) begin
            duty_d       = 8'h00;
            period_d     = '0;
            period_err_d = 1'b1;
            stuck_d      = 1'b1;
            valid_d      = 1'b1;
          end
        end
      end
      HIGH: begin
        if (timeout_hit) begin
          duty_d       = 8'hFF;
          period_d     = '0;
          period_err_d = 1'b1;
          stuck_d      = 1'b1;
          valid_d      = 1'b1;
        end else begin
          per_cnt_d = per_inc;
          if (!fall) hi_cnt_d = hi_inc;
        end
      end
      LOW: begin
        if (rise) begin
          duty_d       = (hi_cnt > DUTY_MAX) ? 8'hFF : hi_cnt[7:0];
          period_d     = per_cnt;
          period_err_d = (per_cnt < PER_LO) || (per_cnt > PER_HI);
          stuck_d      = 1'b0;
          valid_d      = 1'b1;
          hi_cnt_d     = CNT_ONE;
          per_cnt_d    = CNT_ONE;
        end else if (timeout_hit) begin
          duty_d       = 8'h00;
          period_d     = '0;
          period_err_d = 1'b1;
          stuck_d      = 1'b1;
          valid_d      = 1'b1;
        end else begin
          per_cnt_d = per_inc;
        end
      end
      default: begin
        hi_cnt_d  = '0;
        per_cnt_d = '0;
      end
    endcase
  end

  // Counters and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_cnt     <= '0;
      per_cnt    <= '0;
      duty_out   <= 8'h00;
      period_out <= '0;
      valid      <= 1'b0;
      period_err <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      hi_cnt     <= hi_cnt_d;
      per_cnt    <= per_cnt_d;
      duty_out   <= duty_d;
      period_out <= period_d;
      valid      <= valid_d;
      period_err <= period_err_d;
      stuck      <= stuck_d;
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: event-level reference model compared every cycle,
// plus literal expectations on the sequence of reported frames.
module tb_pwm_decoder;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PERIOD  = 256;
  localparam int unsigned TOL     = 2;
  localparam int unsigned TIMEOUT = 1024;
  localparam int HSZ = 1 << 17;
  localparam int NLIT = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic [7:0]       duty_out;
  logic [CNT_W-1:0] period_out;
  logic             valid, period_err, stuck;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_decoder #(.CNT_W(CNT_W), .PERIOD(PERIOD), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty_out(duty_out),
    .period_out(period_out), .valid(valid), .period_err(period_err), .stuck(stuck)
  );

  always #5 clk = ~clk;

  // Reference model: works on the cycle index of each sampled input level
  bit hist [HSZ];
  int cyc = 0;
  int md = 0, mp = 0;
  bit mv = 0, me = 0, ms = 0;
  bit armed = 0, fell = 0;
  int t_rise = 0, t_fall = 0, t_reset = 0;

  task automatic report(input int d, input int p, input bit e, input bit s);
    md = d; mp = p; me = e; ms = s; mv = 1'b1;
  endtask

  always @(posedge clk) begin
    int m, el;
    bit r_e, f_e;
    m = cyc;
    if (m < HSZ) hist[m] = pwm_in;
    if (rst) begin
      for (int k = 0; k < 3; k++) if (m - k >= 0 && m - k < HSZ) hist[m-k] = 1'b0;
      md = 0; mp = 0; mv = 0; me = 0; ms = 0;
      armed = 0; fell = 0; t_reset = m;
    end else begin
      r_e = (m >= 3) && hist[m-2] && !hist[m-3];
      f_e = (m >= 3) && !hist[m-2] && hist[m-3];
      mv = 1'b0;
      el = m - t_rise;
      if (r_e) begin
        if (armed)
          report(((t_fall - t_rise) > 255) ? 255 : (t_fall - t_rise), el,
                 (el < int'(PERIOD - TOL)) || (el > int'(PERIOD + TOL)), 1'b0);
        armed = 1; fell = 0; t_rise = m;
      end else if (armed && el == int'(TIMEOUT)) begin
        report(fell ? 0 : 255, 0, 1'b1, 1'b1);
        armed = 0;
      end else if (!armed && !ms && (m - t_reset - 1) == int'(TIMEOUT)) begin
        report(0, 0, 1'b1, 1'b1);
      end else if (armed && f_e && !fell) begin
        fell = 1; t_fall = m;
      end
    end
    cyc++;
  end

  // Per-cycle comparison and log of DUT-reported frames
  int lg_d[$], lg_p[$];
  bit lg_e[$], lg_s[$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      n_tests++;
      if (duty_out !== 8'(md) || period_out !== CNT_W'(mp) || valid !== mv ||
          period_err !== me || stuck !== ms) begin
        n_fail++;
        $display("FAIL cycle_check cyc=%0d got duty=%h per=%0d v=%b err=%b stk=%b want duty=%h per=%0d v=%b err=%b stk=%b",
                 cyc, duty_out, period_out, valid, period_err, stuck, 8'(md), mp, mv, me, ms);
      end
      if (valid === 1'b1) begin
        lg_d.push_back(int'(duty_out)); lg_p.push_back(int'(period_out));
        lg_e.push_back(period_err);     lg_s.push_back(stuck);
      end
    end
  end

  task automatic drive(input bit lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int p, input int h);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  task automatic check_zero(input string nm);
    n_tests++;
    if (duty_out !== 8'h00 || period_out !== '0 || valid !== 1'b0 ||
        period_err !== 1'b0 || stuck !== 1'b0) begin
      n_fail++;
      $display("FAIL %s got duty=%h per=%0d v=%b err=%b stk=%b want all zero",
               nm, duty_out, period_out, valid, period_err, stuck);
    end
  endtask

  int exp_d [NLIT] = '{8'h7F, 8'h7F, 8'h7F, 8'h52, 8'h41, 8'h00, 8'h7F, 8'hFF, 8'hFF, 8'h1E, 8'h7F};
  int exp_p [NLIT] = '{256, 256, 256, 256, 256, 0, 256, 0, 300, 130, 256};
  bit exp_e [NLIT] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0};
  bit exp_s [NLIT] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};

  initial begin
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    drive(1'b0, 10);

    // Clean red frames, then orange G and indigo B duties, then stuck low
    repeat (3) frame(256, 127);
    frame(256, 82);
    frame(256, 65);
    frame(256, 127);
    drive(1'b0, 1100);

    // Recovery frame, then stuck high
    frame(256, 127);
    drive(1'b1, 1100);
    drive(1'b0, 20);

    // Long period with saturated duty, then reset midway through a high phase
    frame(300, 280);
    drive(1'b1, 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("mid_high_reset");
    drive(1'b1, 30);
    drive(1'b0, 100);
    frame(256, 127);
    frame(256, 127);

    // Randomised frames
    for (int i = 0; i < 40; i++) begin
      int p, h;
      p = $urandom_range(320, 200);
      h = $urandom_range(p - 1, 1);
      frame(p, h);
    end
    drive(1'b0, 1100);
    drive(1'b0, 20);

    n_tests++;
    if (lg_d.size() < NLIT) begin
      n_fail++;
      $display("FAIL valid_count got %0d reports want at least %0d", lg_d.size(), NLIT);
    end else begin
      for (int i = 0; i < NLIT; i++) begin
        n_tests++;
        if (lg_d[i] != exp_d[i] || lg_p[i] != exp_p[i] || lg_e[i] != exp_e[i] || lg_s[i] != exp_s[i]) begin
          n_fail++;
          $display("FAIL report_%0d got duty=%h per=%0d err=%b stk=%b want duty=%h per=%0d err=%b stk=%b",
                   i, lg_d[i], lg_p[i], lg_e[i], lg_s[i], exp_d[i], exp_p[i], exp_e[i], exp_s[i]);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
